// File: rtl/motor_seq_pkg.sv
// rtl/motor_seq_pkg.sv - state encoding and channel search helper shared by motor_sequencer
package motor_seq_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ARMED = ST_ARMED,
    S_RUN   = ST_RUN,
    S_GAP   = ST_GAP,
    S_DONE  = ST_DONE
  } state_t;

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [3:0] next_nonzero(input logic [7:0] mask, input logic [3:0] from);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (4'(i) >= from)) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides clk down to a 1-cycle tick every TICK_DIV cycles
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);

  logic [W-1:0] cnt_q;

  assign tick = (cnt_q == W'(TICK_DIV - 1)) && !restart;

  always_ff @(posedge clk) begin
    if (reset || restart || tick) cnt_q <= '0;
    else                          cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/motor_sequencer.sv
// rtl/motor_sequencer.sv - N-channel dose sequencer driving one motor per channel
// Build option PARALLEL_MODE_EN: run all nonzero channels together on the shared tick.
import motor_seq_pkg::*;

module motor_sequencer #(
  parameter int N_CH      = 3,
  parameter int CNT_W     = 4,
  parameter int TICK_DIV  = 40_000_000,
  parameter int GAP_TICKS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [N_CH*CNT_W-1:0] counts,
  input  logic                  enter,
  input  logic                  abort,
  output logic [N_CH-1:0]       motor,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state,
  output logic [2:0]            ch_idx,
  output logic [CNT_W-1:0]      remaining
);
  state_t                state_q, state_d;
  logic [N_CH*CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]            ch_q, ch_d;
  logic                  enter_q, enter_rise, tick, restart;
  logic [CNT_W-1:0]      ch_cnt [8];
  logic [7:0]            nz_mask;

`ifdef PARALLEL_MODE_EN
  logic [CNT_W-1:0] rem_q [8];
  logic [CNT_W-1:0] rem_d [8];
  logic             more;
`else
  localparam int GAP_W = $clog2(GAP_TICKS + 2);
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [3:0]       first, nxt;
`endif

  // Pad to 8 channels so a 3-bit channel index always selects a defined entry.
  for (genvar g = 0; g < 8; g++) begin : g_ch
    if (g < N_CH) begin : g_used
      assign ch_cnt[g] = cnt_q[g*CNT_W +: CNT_W];
    end else begin : g_pad
      assign ch_cnt[g] = '0;
    end
    assign nz_mask[g] = |ch_cnt[g];
  end

  assign enter_rise = enter && !enter_q;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      enter_q <= 1'b0;
`ifdef PARALLEL_MODE_EN
      rem_q   <= '{default: '0};
`else
      rem_q   <= '0;
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      enter_q <= enter;
      rem_q   <= rem_d;
`ifndef PARALLEL_MODE_EN
      gap_q   <= gap_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    rem_d   = rem_q;
    restart = 1'b1;
`ifdef PARALLEL_MODE_EN
    more = 1'b0;
    for (int i = 0; i < 8; i++) if (rem_q[i] > CNT_W'(1)) more = 1'b1;
`else
    gap_d = gap_q;
    first = next_nonzero(nz_mask, 4'd0);
    nxt   = next_nonzero(nz_mask, {1'b0, ch_q} + 4'd1);
`endif
    unique case (state_q)
      S_IDLE, S_ARMED: begin
        if (load) begin
          cnt_d   = counts;
          state_d = (|counts) ? S_ARMED : S_IDLE;
        end else if (state_q == S_ARMED && enter_rise) begin
`ifdef PARALLEL_MODE_EN
          state_d = S_RUN;
          for (int i = 0; i < 8; i++) rem_d[i] = ch_cnt[i];
`else
          if (first[3]) begin
            state_d = S_RUN;
            ch_d    = first[2:0];
            rem_d   = ch_cnt[first[2:0]];
          end
`endif
        end
      end
      S_RUN: begin
        restart = 1'b0;
        if (tick) begin
`ifdef PARALLEL_MODE_EN
          for (int i = 0; i < 8; i++) if (rem_q[i] != '0) rem_d[i] = rem_q[i] - 1'b1;
          if (!more) state_d = S_DONE;
`else
          if (rem_q > CNT_W'(1)) begin
            rem_d = rem_q - 1'b1;
          end else begin
            rem_d = '0;
            if (!nxt[3]) begin
              state_d = S_DONE;
            end else if (GAP_TICKS > 0) begin
              state_d = S_GAP;
              ch_d    = nxt[2:0];
              gap_d   = GAP_W'(GAP_TICKS);
            end else begin
              ch_d  = nxt[2:0];
              rem_d = ch_cnt[nxt[2:0]];
            end
          end
`endif
        end
      end
      S_GAP: begin
        restart = 1'b0;
`ifndef PARALLEL_MODE_EN
        if (tick) begin
          if (gap_q > GAP_W'(1)) begin
            gap_d = gap_q - 1'b1;
          end else begin
            gap_d   = '0;
            state_d = S_RUN;
            rem_d   = ch_cnt[ch_q];
          end
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        ch_d    = '0;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      ch_d    = '0;
`ifdef PARALLEL_MODE_EN
      for (int i = 0; i < 8; i++) rem_d[i] = '0;
`else
      rem_d = '0;
      gap_d = '0;
`endif
    end
  end

  always_comb begin
    motor = '0;
    if (state_q == S_RUN) begin
      for (int i = 0; i < N_CH; i++) begin
`ifdef PARALLEL_MODE_EN
        motor[i] = (rem_q[i] != '0);
`else
        motor[i] = (ch_q == 3'(i));
`endif
      end
    end
  end

  assign busy   = (state_q == S_RUN) || (state_q == S_GAP);
  assign done   = (state_q == S_DONE);
  assign state  = state_q;
  assign ch_idx = ch_q;
`ifdef PARALLEL_MODE_EN
  assign remaining = rem_q[0];
`else
  assign remaining = rem_q;
`endif
endmodule

// File: doc/motor_sequencer.md
Name: motor_sequencer

Overview:
Parametrised N-channel dose sequencer, next generation of the fixed 3-channel RGB timer/FSM pair. It latches a per-channel run count from the entry logic (keypad memory), then drives one motor output per channel for that many ticks, one channel at a time, with a programmable gap between channels. The tick prescaler is internal, so the block runs on the single system clock and needs no divided clocks. It sits between the keypad/memory path and the motor/LED pins.

Parameters:
N_CH, 3, number of channels/motors (1..8)
CNT_W, 4, width of each channel run count, in ticks
TICK_DIV, 40_000_000, clk cycles per tick (>=2)
GAP_TICKS, 1, idle ticks between consecutive channels (0 = no gap)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
load  in  1  1-cycle strobe: capture counts (accepted in IDLE/ARMED only)
counts  in  N_CH*CNT_W  channel i count at [i*CNT_W +: CNT_W]
enter  in  1  start request, level; rising edge is detected internally
abort  in  1  level; forces stop
motor  out  N_CH  active-high motor enables
busy  out  1  high in RUN or GAP
done  out  1  1-cycle pulse on normal completion
state  out  3  encoded FSM state (LED drive)
ch_idx  out  3  channel currently running/next
remaining  out  CNT_W  ticks left on the current channel

Behaviour:
- Reset (synchronous, active-high): state=IDLE, motor=0, busy=0, done=0, ch_idx=0, remaining=0, count registers cleared, prescaler=0, enter edge register=0.
- Encoding: IDLE=0, ARMED=1, RUN=2, GAP=3, DONE=4.
- IDLE: load -> capture counts; go ARMED next cycle if any count is nonzero, otherwise stay IDLE.
- ARMED: load re-captures (an all-zero load returns to IDLE); an enter rising edge -> select the lowest channel with a nonzero count, remaining=its count, prescaler=0, go RUN. If load and the enter edge coincide, load wins and start is ignored.
- RUN: motor[ch_idx]=1, all others 0. Each TICK_DIV cycles remaining decrements. When remaining reaches 0, motor drops that same cycle. Then:
  - next nonzero channel exists and GAP_TICKS>0 -> GAP;
  - next nonzero channel exists and GAP_TICKS=0 -> RUN directly on it;
  - no further nonzero channel -> DONE.
- Zero-count channels are skipped with no motor pulse and no gap.
- GAP: motor=0 for GAP_TICKS ticks, then RUN on the next channel with a fresh prescaler.
- Tick timing: the first tick of a channel lands TICK_DIV cycles after RUN entry, so a count of k gives motor high for exactly k*TICK_DIV cycles.
- DONE: done=1 for one cycle; count registers cleared; then IDLE.
- abort: any state -> IDLE next cycle; motor=0 that cycle; counts cleared; no done pulse. abort has priority over all other inputs.
- load during RUN/GAP/DONE: ignored. enter edges outside ARMED: ignored.
- A held enter level starts only once; it must fall and rise again to restart.
- Max count (2^CNT_W-1): no wrap; remaining never underflows below 0.
- Only one motor bit is high at any time; in IDLE/ARMED/GAP/DONE motor is 0.

Optional Feature:
PARALLEL_MODE_EN
- Defined: RUN starts all nonzero channels together. Each channel has its own remaining counter on the shared tick, and each motor bit drops when its own counter hits 0. GAP is unused. DONE follows when all counters are 0. ch_idx is held at 0 and remaining reports channel 0.
- Undefined: sequential behaviour as above, and only one remaining counter is built.

Decomposition:
- Package motor_seq_pkg: state enum, state encoding constants, and a helper function that finds the next nonzero channel.
- One sub-module, tick_prescaler: counter to TICK_DIV with a synchronous restart input and a 1-cycle tick output.

Test Plan:
All cases use TICK_DIV=4, GAP_TICKS=1, N_CH=3, CNT_W=4.
- Basic sequence: load counts {2,3,1} (ch0=1, ch1=3, ch2=2), then an enter edge -> motor 001 for 4 cycles, gap 4 cycles, 010 for 12 cycles, gap 4 cycles, 100 for 8 cycles, then a single done pulse, then state=0.
- Skip: load ch0=0, ch1=2, ch2=0, then enter -> only motor[1] high, for 8 cycles; no gap; done follows.
- Abort mid-run: abort asserted during ch1 -> next cycle motor=0, state=IDLE, done never asserted; a later enter edge does nothing until a new load.
- Load edge cases: all-zero load -> stays IDLE; load during RUN -> counts unchanged and sequence completes as originally programmed.
- Enter handling: enter held high from before ARMED -> no start; enter dropped then re-raised -> start; enter edge coincident with load -> no start.
- Reset and width limit: synchronous reset mid-GAP -> all outputs 0 on the next edge. A count of 15 on ch0 -> motor high for exactly 60 cycles.
- With PARALLEL_MODE_EN defined, counts {1,2,3} (ch0=3, ch1=2, ch2=1): motor 111, then 011 after 4 cycles, then 001 after 8, then 000 after 12, then done.
